// File: rtl/costas_loop_filter_if.sv
// Sample/control bundle between the I/Q mixer, the Costas loop filter and the VCO.
interface costas_loop_filter_if #(parameter int DW = 16);
    logic signed [DW-1:0] i_data;
    logic signed [DW-1:0] q_data;
    logic                 in_valid;
    logic                 lock_in;
    logic signed [31:0]   v_g;
    logic                 v_g_valid;
    logic                 locked;
    logic [1:0]           state_o;

    modport master (output i_data, q_data, in_valid, lock_in,
                    input  v_g, v_g_valid, locked, state_o);
    modport slave  (input  i_data, q_data, in_valid, lock_in,
                    output v_g, v_g_valid, locked, state_o);
endinterface

// File: rtl/costas_loop_filter.sv
// Costas phase detector + gear-shifted PI loop filter driving the VCO control word.
// Define COSTAS_PD_SIGN_EN for the decision-directed (sign) phase detector.
module costas_loop_filter #(
    parameter int DW           = 16,
    parameter int KP_SHIFT_ACQ = 8,
    parameter int KI_SHIFT_ACQ = 14,
    parameter int KP_SHIFT_TRK = 10,
    parameter int KI_SHIFT_TRK = 18,
    parameter int LOCK_CNT     = 64
) (
    input  logic                 clk_500,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    costas_loop_filter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACQ = 2'd1, S_TRK = 2'd2} state_t;

    localparam int             CW       = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]  LOCK_MAX = CW'(LOCK_CNT);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx, cnt_inc;
    logic               locked;
    logic [2:1]         vld_pipe;
    logic               accept, upd;
    logic signed [31:0] err_d, err_q, integ, v_g_q;
    logic signed [31:0] p_sh, i_sh, integ_nx, vg_nx;
    logic signed [32:0] isum, vsum;

    function automatic logic signed [31:0] sat32(input logic signed [32:0] x);
        if (x[32] != x[31]) return x[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return x[31:0];
    endfunction

    // IDLE never takes samples; an update needs en still high and no clr
    assign accept = bus.in_valid & en & ~clr & (state != S_IDLE);
    assign upd    = vld_pipe[1] & en & ~clr;

`ifdef COSTAS_PD_SIGN_EN
    localparam logic signed [DW-1:0] QMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] QMAX = ~QMIN;
    logic signed [DW-1:0] pd;

    always_comb begin
        pd = bus.q_data;
        if (bus.i_data[DW-1]) pd = (bus.q_data == QMIN) ? QMAX : -bus.q_data;
    end
    assign err_d = 32'(pd) <<< (DW-1);
`else
    logic signed [2*DW-1:0] prod;

    assign prod  = bus.i_data * bus.q_data;
    assign err_d = 32'(prod);
`endif

    // gains follow the state at the moment the update executes
    assign p_sh     = (state == S_TRK) ? (err_q >>> KP_SHIFT_TRK) : (err_q >>> KP_SHIFT_ACQ);
    assign i_sh     = (state == S_TRK) ? (err_q >>> KI_SHIFT_TRK) : (err_q >>> KI_SHIFT_ACQ);
    assign isum     = 33'(integ) + 33'(i_sh);
    assign integ_nx = sat32(isum);
    assign vsum     = 33'(p_sh) + 33'(integ_nx);
    assign vg_nx    = sat32(vsum);
    assign cnt_inc  = (cnt == LOCK_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (clr) begin
            state_nx = en ? S_ACQ : S_IDLE;
            cnt_nx   = '0;
        end else if (!en) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE: state_nx = S_ACQ;
                S_ACQ: if (upd) begin
                    cnt_nx = bus.lock_in ? cnt_inc : '0;
                    if (cnt_nx == LOCK_MAX) begin
                        state_nx = S_TRK;
                        cnt_nx   = '0;
                    end
                end
                S_TRK: if (upd) begin
                    cnt_nx = bus.lock_in ? '0 : cnt_inc;
                    if (cnt_nx == LOCK_MAX) begin
                        state_nx = S_ACQ;
                        cnt_nx   = '0;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            locked <= (state_nx == S_TRK);
        end
    end

    always_ff @(posedge clk_500 or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_q    <= '0;
            integ    <= '0;
            v_g_q    <= '0;
        end else if (clr) begin
            vld_pipe <= '0;
            err_q    <= '0;
            integ    <= '0;
            v_g_q    <= '0;
        end else begin
            vld_pipe[1] <= accept;
            vld_pipe[2] <= upd;
            if (accept) err_q <= err_d;
            if (upd) begin
                integ <= integ_nx;
                v_g_q <= vg_nx;
            end
        end
    end

    assign bus.v_g       = v_g_q;
    assign bus.v_g_valid = vld_pipe[2];
    assign bus.locked    = locked;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Self-checking bench for costas_loop_filter: vector table, directed corner sequences, random run vs model.
module tb_costas_loop_filter;

    localparam int DW = 16;
    localparam int LOCK_N = 64;

    logic clk_500 = 1'b0;
    logic rst_n   = 1'b0;
    logic en      = 1'b0;
    logic clr     = 1'b0;

    always #1 clk_500 = ~clk_500;

    costas_loop_filter_if #(.DW(DW)) bus ();

    costas_loop_filter #(.DW(DW)) dut (
        .clk_500 (clk_500),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model: plain integer arithmetic on the loop's transactions
    longint m_integ, m_vg, m_err;
    int     m_cnt, m_st;
    bit     m_pend, m_vvalid;

    typedef struct {
        bit     do_clr;
        int     i;
        int     q;
        longint exp_vg;
    } vec_t;

    vec_t tbl[8];

    function automatic longint shr(input longint x, input int k);
        longint d = longint'(1) << k;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic longint pdet(input int i, input int q);
`ifdef COSTAS_PD_SIGN_EN
        int s;
        s = (i >= 0) ? q : ((q == -32768) ? 32767 : -q);
        return longint'(s) * 32768;
`else
        return longint'(i) * longint'(q);
`endif
    endfunction

    task automatic model_reset();
        m_integ = 0; m_vg = 0; m_err = 0; m_cnt = 0; m_st = 0; m_pend = 0; m_vvalid = 0;
    endtask

    task automatic model_step(input bit e, input bit c, input bit v, input int i, input int q, input bit lk);
        bit acc;
        int kp, ki;
        if (c) begin
            m_integ = 0; m_vg = 0; m_cnt = 0; m_pend = 0; m_vvalid = 0;
            m_st = e ? 1 : 0;
        end else if (!e) begin
            m_st = 0; m_pend = 0; m_vvalid = 0; m_cnt = 0;
        end else begin
            acc = v && (m_st != 0);
            m_vvalid = m_pend;
            if (m_pend) begin
                kp = (m_st == 2) ? 10 : 8;
                ki = (m_st == 2) ? 18 : 14;
                m_integ = sat(m_integ + shr(m_err, ki));
                m_vg    = sat(shr(m_err, kp) + m_integ);
                if (m_st == 1) m_cnt = lk ? m_cnt + 1 : 0;
                else           m_cnt = lk ? 0 : m_cnt + 1;
                if (m_cnt >= LOCK_N) begin
                    m_st  = (m_st == 1) ? 2 : 1;
                    m_cnt = 0;
                end
            end else if (m_st == 0) begin
                m_st = 1;
            end
            m_pend = acc;
            if (acc) m_err = pdet(i, q);
        end
    endtask

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // one clock: drive at negedge, advance model, compare at next negedge
    task automatic cyc(input bit e, input bit c, input bit v, input int i, input int q, input bit lk);
        en = e; clr = c;
        bus.in_valid = v;
        bus.i_data   = 16'(i);
        bus.q_data   = 16'(q);
        bus.lock_in  = lk;
        model_step(e, c, v, i, q, lk);
        @(posedge clk_500);
        @(negedge clk_500);
        chk("v_g",       64'($signed(bus.v_g)), m_vg);
        chk("v_g_valid", 64'(bus.v_g_valid),    64'(m_vvalid));
        chk("locked",    64'(bus.locked),       64'(m_st == 2));
        chk("state_o",   64'(bus.state_o),      64'(m_st));
    endtask

    initial begin
        bit seen_valid, seen_neg;
        int lkp;

        tbl[0] = '{1'b1,  1000,  1000,  3967};
        tbl[1] = '{1'b0,  1000,  1000,  4028};
        tbl[2] = '{1'b1,  1000, -1000, -3969};
        tbl[3] = '{1'b1, -1000, -1000,  3967};
        tbl[4] = '{1'b1,     0,     5,     0};
        tbl[5] = '{1'b1,     1,    -1,    -2};
        tbl[6] = '{1'b0,     1,    -1,    -3};
        tbl[7] = '{1'b1, 32767, 32767, 4259580};

        bus.in_valid = 1'b0; bus.i_data = '0; bus.q_data = '0; bus.lock_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_500);
        chk("rst_v_g",   64'($signed(bus.v_g)), 0);
        chk("rst_valid", 64'(bus.v_g_valid), 0);
        chk("rst_state", 64'(bus.state_o), 0);
        chk("rst_lock",  64'(bus.locked), 0);
        rst_n = 1'b1;

        // idle: samples ignored while en=0
        seen_valid = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 1, 1000 + k, 500, 1);
            if (bus.v_g_valid) seen_valid = 1;
        end
        chk("idle_no_valid", 64'(seen_valid), 0);
        chk("idle_v_g",      64'($signed(bus.v_g)), 0);
        chk("idle_state",    64'(bus.state_o), 0);

        for (int k = 0; k < 8; k++) begin
            if (tbl[k].do_clr) cyc(1, 1, 0, 0, 0, 0);
            cyc(1, 0, 1, tbl[k].i, tbl[k].q, 0);
            cyc(1, 0, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_valid", k), 64'(bus.v_g_valid), 1);
            chk($sformatf("tbl%0d_v_g", k),   64'($signed(bus.v_g)), tbl[k].exp_vg);
        end

        // gear shift ACQ -> TRK -> ACQ
        cyc(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < LOCK_N; k++) cyc(1, 0, 1, 1000, 1000, 1);
        chk("pre_lock", 64'(bus.locked), 0);
        cyc(1, 0, 0, 0, 0, 1);
        chk("gear_locked", 64'(bus.locked), 1);
        chk("gear_state",  64'(bus.state_o), 2);
        cyc(1, 0, 1, 1000, 1000, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("trk_v_g", 64'($signed(bus.v_g)), 4883);
        for (int k = 0; k < LOCK_N - 1; k++) cyc(1, 0, 1, 1000, 1000, 0);
        chk("trk_hold", 64'(bus.state_o), 2);
        cyc(1, 0, 0, 0, 0, 0);
        chk("unlock_state",  64'(bus.state_o), 1);
        chk("unlock_locked", 64'(bus.locked), 0);

        // saturation with err = 2^30
        cyc(1, 1, 0, 0, 0, 0);
        seen_neg = 0;
        for (int k = 0; k < 32800; k++) begin
            cyc(1, 0, 1, -32768, -32768, 0);
            if ($signed(bus.v_g) < 0) seen_neg = 1;
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("sat_v_g",    64'($signed(bus.v_g)), 2147483647);
        chk("sat_nonneg", 64'(seen_neg), 0);

        // clr together with a sample drops it
        cyc(1, 1, 1, 1000, 1000, 0);
        seen_valid = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, 0, 0);
            if (bus.v_g_valid) seen_valid = 1;
        end
        chk("clr_no_valid", 64'(seen_valid), 0);
        chk("clr_v_g",      64'($signed(bus.v_g)), 0);

        // en dropped while a sample is in flight
        cyc(1, 0, 1, 1000, 1000, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("en_pre_v_g", 64'($signed(bus.v_g)), 3967);
        cyc(1, 0, 1, 1000, 1000, 0);
        seen_valid = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (bus.v_g_valid) seen_valid = 1;
        end
        chk("en_drop_no_valid", 64'(seen_valid), 0);
        chk("en_drop_v_g",      64'($signed(bus.v_g)), 3967);
        chk("en_drop_state",    64'(bus.state_o), 0);

        // randomized run against the model
        cyc(1, 1, 0, 0, 0, 0);
        lkp = 98;
        for (int k = 0; k < 4000; k++) begin
            if (k % 150 == 0) lkp = ($urandom_range(0, 1) == 1) ? 99 : 1;
            cyc(1,
                ($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 7),
                $signed(16'($urandom)),
                $signed(16'($urandom)),
                ($urandom_range(0, 99) < lkp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
